// File: rtl/toxic_fetch_pkg.sv
// toxic_pkg: shared types and constants for the fetch stage.
//   DEF_PC_W / DEF_INSTR_W : default address and instruction widths
//   FETCH_DEPTH            : instruction buffer depth (buffered + in flight)
//   pc_t, instr_t          : address / instruction words
//   fetch_entry_t          : one buffered fetch result {pc, instr}
//   ptr_inc                : modulo-FETCH_DEPTH pointer increment
package toxic_pkg;

    localparam int DEF_PC_W    = 8;
    localparam int DEF_INSTR_W = 8;
    localparam int FETCH_DEPTH = 3;

    typedef logic [DEF_INSTR_W-1:0] instr_t;
    typedef logic [DEF_PC_W-1:0]    pc_t;

    typedef struct packed {
        pc_t    pc;
        instr_t instr;
    } fetch_entry_t;

    // Pointers run 0..FETCH_DEPTH-1; the depth is not a power of two so
    // the wrap has to be explicit.
    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'(FETCH_DEPTH - 1)) ? 2'd0 : p + 2'd1;
    endfunction

endpackage

// File: rtl/toxic_fetch_if.sv
// toxic_fetch_if: bundles the fetch stage's memory, redirect and
// core-facing handshake signals.
//   imem_req_valid/imem_addr : read request to instruction memory
//   imem_rdata               : read data, one cycle after the request
//   redirect_valid/pc        : PC change requested by the core
//   out_valid/ready/instr/pc : instruction handshake towards the core
// modport master: the fetch stage.  modport slave: memory + core side.
interface toxic_fetch_if #(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 8
);
    logic               imem_req_valid;
    logic [PC_W-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               redirect_valid;
    logic [PC_W-1:0]    redirect_pc;
    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] out_instr;
    logic [PC_W-1:0]    out_pc;

    modport master (
        output imem_req_valid, imem_addr, out_valid, out_instr, out_pc,
        input  imem_rdata, redirect_valid, redirect_pc, out_ready
    );

    modport slave (
        input  imem_req_valid, imem_addr, out_valid, out_instr, out_pc,
        output imem_rdata, redirect_valid, redirect_pc, out_ready
    );
endinterface

// File: rtl/toxic_fetch_buf.sv
// toxic_fetch_buf: 3-entry synchronous FIFO of fetch_entry_t.
//   clk, rst : clock, synchronous active-high reset
//   push/din : write din at the tail
//   pop      : drop the head (ignored when empty)
//   flush    : empty the FIFO at the edge; wins over push
//   count    : current occupancy 0..3
//   head     : oldest entry, reads as zero when empty
module toxic_fetch_buf
    import toxic_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t din,
    output logic [1:0]   count,
    output fetch_entry_t head
);

    fetch_entry_t mem [FETCH_DEPTH];
    logic [1:0]   rd_ptr;
    logic [1:0]   wr_ptr;
    logic         do_pop;
    logic         do_push;

    assign do_pop  = pop && (count != 2'd0);
    // A push into a full FIFO is only accepted when a pop frees a slot in
    // the same cycle.
    assign do_push = push && ((count != 2'(FETCH_DEPTH)) || do_pop);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= 2'd0;
            wr_ptr <= 2'd0;
            count  <= 2'd0;
        end else begin
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the head is masked whenever count is zero.
    always_ff @(posedge clk) begin
        if (do_push && !flush && !rst) mem[wr_ptr] <= din;
    end

    assign head = (count == 2'd0) ? '0 : mem[rd_ptr];

endmodule

// File: rtl/toxic_fetch.sv
// toxic_fetch: instruction fetch stage in front of toxic_core.
// Owns the PC, issues one-cycle-latency reads to instruction memory,
// buffers up to three results and presents them to the core over a
// valid/ready handshake. Core redirects flush everything in flight.
//   clk, rst : clock, synchronous active-high reset
//   bus      : toxic_fetch_if.master (memory request/response, redirect,
//              core handshake)
module toxic_fetch
    import toxic_pkg::*;
#(
    parameter int              PC_W     = DEF_PC_W,
    parameter int              INSTR_W  = DEF_INSTR_W,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst,
    toxic_fetch_if.master bus
);

    logic [PC_W-1:0] pc_q;
    logic            inflight_q;
    logic [PC_W-1:0] inflight_pc_q;

    logic [1:0]      count;
    fetch_entry_t    head;
    fetch_entry_t    push_entry;
    logic [2:0]      pending;
    logic            issue;
    logic            push;
    logic            pop;
    logic            out_valid;

    // Occupancy counts the outstanding request too, so a response always
    // finds a free slot. Only registered state feeds this (no out_ready
    // path): a pop frees issue capacity one cycle later.
    assign pending = {1'b0, count} + {2'b00, inflight_q};
    assign issue   = !rst && !bus.redirect_valid && (pending < 3'(FETCH_DEPTH));

    // A response landing in a redirect cycle is stale and dropped.
    assign push       = inflight_q && !bus.redirect_valid;
    assign push_entry = '{pc: inflight_pc_q, instr: bus.imem_rdata};

    assign out_valid = !rst && (count != 2'd0);
    assign pop       = out_valid && bus.out_ready;

    toxic_fetch_buf u_buf (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (bus.redirect_valid),
        .din   (push_entry),
        .count (count),
        .head  (head)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else if (bus.redirect_valid) begin
            pc_q       <= bus.redirect_pc;
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= issue;
            if (issue) begin
                pc_q          <= pc_q + PC_W'(1);
                inflight_pc_q <= pc_q;
            end
        end
    end

    // While rst is high the outputs show reset values even though the
    // registers only clear at the next edge.
    assign bus.imem_req_valid = issue;
    assign bus.imem_addr      = rst ? RESET_PC : pc_q;
    assign bus.out_valid      = out_valid;
    assign bus.out_pc         = rst ? '0 : head.pc;
    assign bus.out_instr      = rst ? '0 : head.instr;

endmodule

// File: tb/tb_toxic_fetch.sv
// tb_toxic_fetch: self-checking bench for toxic_fetch. A transaction-level
// scoreboard (expected PC, in-flight request, queue of buffered PCs) is
// compared against the DUT every cycle; scenario tasks add targeted timing
// and ordering checks on top.
module tb_toxic_fetch;
    import toxic_pkg::*;

    localparam logic [7:0] RESET_PC = 8'h00;

    logic clk = 1'b0;
    logic rst;

    toxic_fetch_if #(.PC_W(8), .INSTR_W(8)) bus ();

    toxic_fetch #(.PC_W(8), .INSTR_W(8), .RESET_PC(RESET_PC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Instruction memory: instr = addr ^ A5, one cycle after the request.
    always @(posedge clk)
        bus.imem_rdata <= bus.imem_req_valid ? (bus.imem_addr ^ 8'hA5) : 8'h5A;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Scoreboard state
    logic [7:0] m_pc     = RESET_PC;
    logic       m_inf    = 1'b0;
    logic [7:0] m_inf_pc = 8'h00;
    logic [7:0] m_q[$];
    logic [7:0] delivered[$];

    always @(negedge clk) begin
        logic       exp_req;
        logic       exp_ov;
        logic [7:0] exp_opc;
        logic [7:0] exp_oin;
        logic       hs;
        cyc++;
        exp_req = !rst && !bus.redirect_valid && ((m_q.size() + int'(m_inf)) < 3);
        exp_ov  = !rst && (m_q.size() > 0);
        exp_opc = exp_ov ? m_q[0] : 8'h00;
        exp_oin = exp_ov ? (m_q[0] ^ 8'hA5) : 8'h00;

        checks++;
        if (bus.imem_req_valid !== exp_req) begin
            errors++;
            $display("FAIL sb_req cyc=%0d got=%b exp=%b", cyc, bus.imem_req_valid, exp_req);
        end
        checks++;
        if (bus.imem_addr !== (rst ? RESET_PC : m_pc)) begin
            errors++;
            $display("FAIL sb_addr cyc=%0d got=%h exp=%h", cyc, bus.imem_addr, rst ? RESET_PC : m_pc);
        end
        checks++;
        if (bus.out_valid !== exp_ov || bus.out_pc !== exp_opc || bus.out_instr !== exp_oin) begin
            errors++;
            $display("FAIL sb_out cyc=%0d got v=%b pc=%h in=%h exp v=%b pc=%h in=%h",
                     cyc, bus.out_valid, bus.out_pc, bus.out_instr, exp_ov, exp_opc, exp_oin);
        end

        hs = exp_ov && bus.out_ready;
        if (hs) delivered.push_back(exp_opc);

        if (rst) begin
            m_q.delete();
            m_inf = 1'b0;
            m_pc  = RESET_PC;
        end else if (bus.redirect_valid) begin
            m_q.delete();
            m_inf = 1'b0;
            m_pc  = bus.redirect_pc;
        end else begin
            if (hs) void'(m_q.pop_front());
            if (m_inf) m_q.push_back(m_inf_pc);
            m_inf = exp_req;
            if (exp_req) begin
                m_inf_pc = m_pc;
                m_pc     = m_pc + 8'd1;
            end
        end
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench at the start of the first cycle with rst=0.
    task automatic do_reset(input logic ready);
        rst                = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.out_ready      = ready;
        next();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst                = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 8'h00;
        bus.out_ready      = 1'b1;
        next();
        next();
        @(negedge clk);
        checks++;
        if (bus.imem_req_valid !== 1'b0 || bus.imem_addr !== RESET_PC) begin
            errors++;
            $display("FAIL reset_req got v=%b a=%h exp v=0 a=%h", bus.imem_req_valid, bus.imem_addr, RESET_PC);
        end
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_pc !== 8'h00 || bus.out_instr !== 8'h00) begin
            errors++;
            $display("FAIL reset_out got v=%b pc=%h in=%h exp 0/00/00", bus.out_valid, bus.out_pc, bus.out_instr);
        end
    endtask

    task automatic test_startup();
        do_reset(1'b1);
        @(negedge clk);
        checks++;
        if (bus.imem_req_valid !== 1'b1 || bus.imem_addr !== RESET_PC || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL start_c0 got req=%b a=%h ov=%b exp 1/%h/0", bus.imem_req_valid, bus.imem_addr, bus.out_valid, RESET_PC);
        end
        next();
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL start_c1 got ov=%b exp 0", bus.out_valid);
        end
        for (int i = 0; i < 4; i++) begin
            next();
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_pc !== 8'(i) || bus.out_instr !== (8'(i) ^ 8'hA5)) begin
                errors++;
                $display("FAIL start_seq%0d got v=%b pc=%h in=%h exp 1/%h/%h",
                         i, bus.out_valid, bus.out_pc, bus.out_instr, 8'(i), 8'(i) ^ 8'hA5);
            end
        end
    endtask

    task automatic test_backpressure();
        int nreq = 0;
        do_reset(1'b0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.imem_req_valid) nreq++;
            next();
        end
        checks++;
        if (nreq != 3) begin
            errors++;
            $display("FAIL bp_reqs got=%0d exp=3", nreq);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.imem_req_valid !== 1'b0 || bus.out_pc !== 8'h00) begin
            errors++;
            $display("FAIL bp_pop0 got req=%b pc=%h exp 0/00", bus.imem_req_valid, bus.out_pc);
        end
        next();
        @(negedge clk);
        checks++;
        if (bus.imem_req_valid !== 1'b1 || bus.imem_addr !== 8'h03 || bus.out_pc !== 8'h01) begin
            errors++;
            $display("FAIL bp_resume got req=%b a=%h pc=%h exp 1/03/01", bus.imem_req_valid, bus.imem_addr, bus.out_pc);
        end
        next();
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_pc !== 8'h02) begin
            errors++;
            $display("FAIL bp_pop2 got v=%b pc=%h exp 1/02", bus.out_valid, bus.out_pc);
        end
        next();
    endtask

    task automatic test_redirect();
        int bad = 0;
        do_reset(1'b0);
        next(); next(); next();
        // Two entries buffered (00, 01) and 02 in flight.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 8'h40;
        next();
        bus.redirect_valid = 1'b0;
        bus.out_ready      = 1'b1;
        delivered.delete();
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.imem_req_valid !== 1'b1 || bus.imem_addr !== 8'h40) begin
            errors++;
            $display("FAIL redir_r1 got ov=%b req=%b a=%h exp 0/1/40", bus.out_valid, bus.imem_req_valid, bus.imem_addr);
        end
        next();
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL redir_r2 got ov=%b exp 0", bus.out_valid);
        end
        next();
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_pc !== 8'h40 || bus.out_instr !== 8'hE5) begin
            errors++;
            $display("FAIL redir_r3 got v=%b pc=%h in=%h exp 1/40/e5", bus.out_valid, bus.out_pc, bus.out_instr);
        end
        repeat (6) next();
        foreach (delivered[i]) if (delivered[i] !== 8'(8'h40 + i)) bad++;
        checks++;
        if (bad != 0 || delivered.size() < 6) begin
            errors++;
            $display("FAIL redir_order got bad=%0d n=%0d exp bad=0 n>=6", bad, delivered.size());
        end
    endtask

    task automatic test_wrap();
        logic [7:0] exp_seq [4];
        exp_seq = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        do_reset(1'b1);
        next(); next(); next();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 8'hFE;
        next();
        bus.redirect_valid = 1'b0;
        delivered.delete();
        repeat (8) next();
        checks++;
        if (delivered.size() < 4) begin
            errors++;
            $display("FAIL wrap_count got=%0d exp>=4", delivered.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (delivered[i] !== exp_seq[i]) begin
                    errors++;
                    $display("FAIL wrap_pc%0d got=%h exp=%h", i, delivered[i], exp_seq[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int stale = 0;
        do_reset(1'b0);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 8'h80;
        next();
        bus.redirect_valid = 1'b0;
        repeat (6) next();
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_pc !== 8'h80) begin
            errors++;
            $display("FAIL rmid_full got v=%b pc=%h exp 1/80", bus.out_valid, bus.out_pc);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_pc !== 8'h00 || bus.out_instr !== 8'h00 ||
            bus.imem_req_valid !== 1'b0 || bus.imem_addr !== RESET_PC) begin
            errors++;
            $display("FAIL rmid_rst got v=%b pc=%h in=%h req=%b a=%h exp 0/00/00/0/%h",
                     bus.out_valid, bus.out_pc, bus.out_instr, bus.imem_req_valid, bus.imem_addr, RESET_PC);
        end
        next();
        rst           = 1'b0;
        bus.out_ready = 1'b1;
        delivered.delete();
        repeat (8) next();
        foreach (delivered[i]) if (delivered[i][7]) stale++;
        checks++;
        if (stale != 0 || delivered.size() == 0 || delivered[0] !== RESET_PC) begin
            errors++;
            $display("FAIL rmid_restart got stale=%0d n=%0d first=%h exp 0/>0/%h",
                     stale, delivered.size(), delivered.size() ? delivered[0] : 8'hxx, RESET_PC);
        end
    endtask

    task automatic test_redirect_handshake();
        int  seen10 = 0;
        int  t      = 0;
        do_reset(1'b0);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 8'h05;
        next();
        bus.redirect_valid = 1'b0;
        while (t < 10) begin
            @(negedge clk);
            if (bus.out_valid) break;
            next();
            t++;
        end
        checks++;
        if (t >= 10) begin
            errors++;
            $display("FAIL rh_wait got timeout exp out_valid within 10 cycles");
        end
        next();
        bus.out_ready      = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 8'h10;
        delivered.delete();
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_pc !== 8'h05) begin
            errors++;
            $display("FAIL rh_head got v=%b pc=%h exp 1/05", bus.out_valid, bus.out_pc);
        end
        next();
        bus.redirect_pc = 8'h20;
        @(negedge clk);
        checks++;
        if (bus.imem_req_valid !== 1'b0 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rh_hold got req=%b ov=%b exp 0/0", bus.imem_req_valid, bus.out_valid);
        end
        next();
        bus.redirect_valid = 1'b0;
        repeat (8) next();
        foreach (delivered[i]) if (delivered[i] == 8'h10) seen10++;
        checks++;
        if (delivered.size() < 2 || delivered[0] !== 8'h05 || delivered[1] !== 8'h20 || seen10 != 0) begin
            errors++;
            $display("FAIL rh_order got n=%0d d0=%h d1=%h seen10=%0d exp >=2/05/20/0",
                     delivered.size(), delivered.size() > 0 ? delivered[0] : 8'hxx,
                     delivered.size() > 1 ? delivered[1] : 8'hxx, seen10);
        end
    endtask

    initial begin
        test_reset();
        test_startup();
        test_backpressure();
        test_redirect();
        test_wrap();
        test_reset_mid();
        test_redirect_handshake();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
